instr_mem_responder: RTL and testbench

//  Synthesizable instruction-memory responder: the memory end of the core's

---
 rtl/instr_mem_responder.sv | 137 +++++++++++++
 tb/tb_instr_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder for the core's req/gnt/rvalid fetch port, with a word preload port.
// Optional macro INSTR_MEM_ERR_EN: grant out-of-range fetches and answer them with an error response.
module instr_mem_responder #(
    parameter int N_WORDS     = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        ld_we_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_wdata_i
);

    localparam int          IDX_W      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int          CNT_W      = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [31:0] BYTE_LIMIT = 32'(N_WORDS * 4);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [31:0]      mem [N_WORDS];
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic [31:0]      held_addr;
    logic             in_range;
    logic             accept;
    logic             gnt;
    logic             ld_in_range;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] ld_idx;

    assign in_range    = instr_addr_i < BYTE_LIMIT;
    assign idx         = instr_addr_i[IDX_W+1:2];
    assign ld_in_range = ld_addr_i < BYTE_LIMIT;
    assign ld_idx      = ld_addr_i[IDX_W+1:2];

`ifdef INSTR_MEM_ERR_EN
    assign accept = instr_req_i;
`else
    assign accept = instr_req_i & in_range;
`endif

    always_comb begin
        gnt          = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        gnt = 1'b1;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                // A core that withdraws or retargets its request simply starts over.
                if (!instr_req_i || (instr_addr_i != held_addr)) begin
                    state_nxt    = S_IDLE;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == CNT_W'(WAIT_STATES)) begin
                    gnt          = 1'b1;
                    state_nxt    = S_IDLE;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = S_IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    assign instr_gnt_o = gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE) begin
            held_addr <= instr_addr_i;
        end
    end

    // Response stage: the read here sees the pre-write word when a preload hits the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_rvalid_o <= 1'b0;
            instr_rdata_o  <= '0;
        end else begin
            instr_rvalid_o <= gnt;
            if (gnt) begin
                instr_rdata_o <= in_range ? mem[idx] : '0;
            end
        end
    end

`ifdef INSTR_MEM_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_err_o <= 1'b0;
        end else if (gnt) begin
            instr_err_o <= !in_range;
        end else begin
            instr_err_o <= 1'b0;
        end
    end
`else
    assign instr_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (ld_we_i && ld_in_range) begin
            mem[ld_idx] <= ld_wdata_i;
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench: one responder with zero wait states, one with two, sharing clock, reset and preload bus.
module tb_instr_mem_responder;

    localparam int N_WORDS = 16;
    localparam int WS1     = 2;
`ifdef INSTR_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        ld_we;
    logic [31:0] ld_addr, ld_wdata;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] model [N_WORDS];
    resp_t       q0[$];
    resp_t       q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_mem_responder #(.N_WORDS(N_WORDS), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .instr_req_i(req0), .instr_addr_i(addr0), .instr_gnt_o(gnt0),
        .instr_rvalid_o(rvalid0), .instr_rdata_o(rdata0), .instr_err_o(err0),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata)
    );

    instr_mem_responder #(.N_WORDS(N_WORDS), .WAIT_STATES(WS1)) dut1 (
        .clk(clk), .rst(rst),
        .instr_req_i(req1), .instr_addr_i(addr1), .instr_gnt_o(gnt1),
        .instr_rvalid_o(rvalid1), .instr_rdata_o(rdata1), .instr_err_o(err1),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return a < 32'(N_WORDS * 4);
    endfunction

    // Reference behaviour: in-range fetch returns the stored word, anything else an error word.
    function automatic resp_t expect_resp(input logic [31:0] a, input int at);
        resp_t r;
        r.cyc = at;
        if (in_rng(a)) begin
            r.err  = 1'b0;
            r.data = model[a[5:2]];
        end else begin
            r.err  = 1'b1;
            r.data = 32'h0;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        resp_t e;
        if (q0.size() > 0 && q0[0].cyc == cyc) begin
            e = q0.pop_front();
            check("rvalid0", 32'(rvalid0), 32'd1);
            if (rvalid0) begin
                check("rdata0", rdata0, e.data);
                check("err0", 32'(err0), 32'(e.err));
            end
        end else if (rvalid0) begin
            checks++;
            errors++;
            $display("FAIL rvalid0_unexpected: got rvalid=1 rdata=%h expected no response (cycle %0d)", rdata0, cyc);
        end
    end

    always @(negedge clk) begin
        resp_t e;
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            e = q1.pop_front();
            check("rvalid1", 32'(rvalid1), 32'd1);
            if (rvalid1) begin
                check("rdata1", rdata1, e.data);
                check("err1", 32'(err1), 32'(e.err));
            end
        end else if (rvalid1) begin
            checks++;
            errors++;
            $display("FAIL rvalid1_unexpected: got rvalid=1 rdata=%h expected no response (cycle %0d)", rdata1, cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_wdata = d;
        step();
        ld_we = 1'b0;
        if (in_rng(a)) model[a[5:2]] = d;
    endtask

    // One request cycle on the zero-wait responder; request is left high for back-to-back use.
    task automatic fetch0(input logic [31:0] a);
        bit ok;
        req0 = 1'b1; addr0 = a;
        ok = in_rng(a) || ERR_EN;
        @(negedge clk);
        check("gnt0", 32'(gnt0), 32'(ok));
        if (ok) q0.push_back(expect_resp(a, cyc + 1));
        step();
    endtask

    task automatic fetch1(input logic [31:0] a);
        bit ok;
        bit g;
        req1 = 1'b1; addr1 = a;
        ok = in_rng(a) || ERR_EN;
        for (int k = 0; k <= WS1; k++) begin
            g = ok && (k == WS1);
            @(negedge clk);
            check("gnt1", 32'(gnt1), 32'(g));
            if (g) q1.push_back(expect_resp(a, cyc + 1));
            step();
        end
        req1 = 1'b0;
    endtask

    // Withdraw (retarget=0) or retarget (retarget=1) a waiting request after one cycle.
    task automatic abort1(input logic [31:0] a, input bit retarget);
        req1 = 1'b1; addr1 = a;
        @(negedge clk);
        check("gnt1_abort_first", 32'(gnt1), 32'd0);
        step();
        if (retarget) begin
            addr1 = a ^ 32'h4;
        end else begin
            req1 = 1'b0;
        end
        @(negedge clk);
        check("gnt1_abort_second", 32'(gnt1), 32'd0);
        step();
        req1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          n;

        rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        req0 = 1'b1; addr0 = 32'h0;
        req1 = 1'b1; addr1 = 32'h40;
        step();
        step();
        @(negedge clk);
        check("rst_gnt0_inrange", 32'(gnt0), 32'd1);
        check("rst_gnt1_waiting", 32'(gnt1), 32'd0);
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rvalid1", 32'(rvalid1), 32'd0);
        check("rst_rdata1", rdata1, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("post_rst_rvalid0", 32'(rvalid0), 32'd0);
        check("post_rst_rdata0", rdata0, 32'h0);
        check("post_rst_err0", 32'(err0), 32'd0);
        step();

        for (int i = 0; i < N_WORDS; i++) preload(32'(i * 4), $urandom);
        preload(32'h0, 32'h00000033);
        preload(32'h4, 32'h00000493);
        preload(32'h8, 32'h00f00293);
        preload(32'hC, 32'h00048663);
        preload(32'h44, 32'hBAD0BAD0);

        for (int i = 0; i < 4; i++) fetch0(32'(i * 4));
        req0 = 1'b0;
        step();

        fetch1(32'h8);
        step();
        abort1(32'h8, 1'b0);
        abort1(32'h8, 1'b1);
        fetch1(32'hC);
        step();

        req0 = 1'b1; addr0 = 32'h4;
        ld_we = 1'b1; ld_addr = 32'h4; ld_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("gnt0_rbw", 32'(gnt0), 32'd1);
        q0.push_back(expect_resp(32'h4, cyc + 1));
        step();
        model[1] = 32'hDEADBEEF;
        ld_we = 1'b0; req0 = 1'b0;
        step();
        fetch0(32'h4);
        req0 = 1'b0;
        step();

        for (int i = 0; i < 10; i++) fetch0(32'h40);
        req0 = 1'b0;
        fetch1(32'h40);
        step();

        req0 = 1'b1; addr0 = 32'h8;
        @(negedge clk);
        check("gnt0_before_rst", 32'(gnt0), 32'd1);
        rst = 1'b1;
        step();
        req0 = 1'b0;
        @(negedge clk);
        check("rvalid0_dropped", 32'(rvalid0), 32'd0);
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        check("rvalid0_after_rst", 32'(rvalid0), 32'd0);
        step();
        fetch0(32'h8);
        req0 = 1'b0;
        step();

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = 32'($urandom_range(0, N_WORDS * 4 + 15));
                    d = $urandom;
                    preload(a, d);
                end
                1: begin
                    n = $urandom_range(1, 5);
                    for (int j = 0; j < n; j++) fetch0(32'($urandom_range(0, N_WORDS * 4 + 15)));
                    req0 = 1'b0;
                    step();
                end
                2: begin
                    fetch1(32'($urandom_range(0, N_WORDS * 4 + 15)));
                end
                default: begin
                    abort1(32'($urandom_range(0, N_WORDS - 1) * 4), 1'($urandom_range(0, 1)));
                end
            endcase
        end

        step();
        step();
        step();
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
